// File: rtl/ifetch_resp.sv
// Instruction fetch responder: serves 32-bit instructions for the fetch PC from a
// one-entry 64-bit line buffer, falling back to a variable-latency 64-bit memory
// read on a miss. Faults (misaligned PC, bus error, timeout) return FAULT_INS.
module ifetch_resp #(
    parameter int          TIMEOUT   = 256,
    parameter logic [31:0] FAULT_INS = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] pc,
    input  logic        fence_i,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        fetch_fault,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    input  logic        mem_err
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_RESP} state_t;

    state_t           state, state_nxt;

    // Line buffer: one doubleword plus its 61-bit tag
    logic [63:0]      line_buf;
    logic [60:0]      buf_tag;
    logic             buf_valid;

    logic [CNT_W-1:0] cnt, cnt_d;
    logic [31:0]      instr_d;
    logic             valid_d, fault_d, req_d, buf_load;
    logic [63:0]      addr_d;

    logic             misaligned, hit, timed_out;

    assign misaligned = (pc[1:0] != 2'b00);
    // Uses the pre-fence valid bit, so a fence in the same cycle still lets this access hit
    assign hit        = buf_valid && (buf_tag == pc[63:3]);
    assign timed_out  = (cnt == CNT_LAST);

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= 64'h0;
            cnt         <= '0;
        end else begin
            state       <= state_nxt;
            instr       <= instr_d;
            instr_valid <= valid_d;
            fetch_fault <= fault_d;
            mem_req     <= req_d;
            mem_addr    <= addr_d;
            cnt         <= cnt_d;
        end
    end

    // Line buffer update; a fence in the same cycle as a fill leaves the buffer invalid
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
        end else begin
            if (fence_i)       buf_valid <= 1'b0;
            else if (buf_load) buf_valid <= 1'b1;
        end
        if (buf_load) begin
            line_buf <= mem_rdata;
            buf_tag  <= pc[63:3];
        end
    end

    // Next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = (misaligned || hit) ? S_RESP : S_MEM;
            S_MEM:   if (mem_rvalid || timed_out) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, counter and buffer fill strobe
    always_comb begin
        instr_d  = instr;
        valid_d  = 1'b0;
        fault_d  = 1'b0;
        req_d    = 1'b0;
        addr_d   = mem_addr;
        cnt_d    = cnt;
        buf_load = 1'b0;
        case (state)
            S_IDLE: begin
                if (misaligned) begin
                    valid_d = 1'b1;
                    fault_d = 1'b1;
                    instr_d = FAULT_INS;
                end else if (hit) begin
                    valid_d = 1'b1;
                    instr_d = pc[2] ? line_buf[63:32] : line_buf[31:0];
                end else begin
                    req_d  = 1'b1;
                    addr_d = {pc[63:3], 3'b000};
                    cnt_d  = '0;
                end
            end
            S_MEM: begin
                // Data arriving on the timeout cycle is still accepted
                if (mem_rvalid) begin
                    valid_d = 1'b1;
                    if (mem_err) begin
                        fault_d = 1'b1;
                        instr_d = FAULT_INS;
                    end else begin
                        instr_d  = pc[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                        buf_load = 1'b1;
                    end
                end else if (timed_out) begin
                    valid_d = 1'b1;
                    fault_d = 1'b1;
                    instr_d = FAULT_INS;
                end else begin
                    req_d = 1'b1;
                    if (cnt != '1) cnt_d = cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ifetch_resp.sv
// Bench for ifetch_resp: the bench acts as fetch stage and backing memory, and
// predicts every response from a transaction-level model of the line buffer.
module tb_ifetch_resp;

    localparam int          TIMEOUT   = 8;
    localparam logic [31:0] FAULT_INS = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc;
    logic        fence_i;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_fault;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    // Reference model of the line buffer
    logic        m_valid;
    logic [60:0] m_tag;
    logic [63:0] m_line;

    ifetch_resp #(.TIMEOUT(TIMEOUT), .FAULT_INS(FAULT_INS)) dut (
        .clk(clk), .rst(rst), .pc(pc), .fence_i(fence_i),
        .instr(instr), .instr_valid(instr_valid), .fetch_fault(fetch_fault),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One fetch transaction; called at a negedge with the DUT idle.
    // lat: req-high cycle index at which rvalid is returned (>=TIMEOUT means never)
    // fmode: 0 none, 1 fence during the sampling cycle, 2 fence with rvalid
    task automatic fetch(input logic [63:0] a, input int lat, input logic err,
                         input logic [63:0] rd, input int fmode, input logic stray);
        logic        mis, hit, drove, done, exp_f;
        logic [31:0] exp_i;
        int          k;
        mis = (a[1:0] != 2'b00);
        hit = !mis && m_valid && (m_tag == a[63:3]);
        exp_i = mis ? FAULT_INS : (a[2] ? m_line[63:32] : m_line[31:0]);
        exp_f = mis;
        pc = a;
        fence_i = (fmode == 1);
        if (stray) begin
            mem_rvalid = 1'b1; mem_rdata = rd; mem_err = 1'b0;
        end
        @(posedge clk); @(negedge clk);
        fence_i = 1'b0; mem_rvalid = 1'b0;
        if (fmode == 1) m_valid = 1'b0;
        if (mis || hit) begin
            chk("fast_valid", instr_valid, 1'b1);
            chk("fast_noreq", mem_req, 1'b0);
            chk("fast_fault", fetch_fault, exp_f);
            chk("fast_instr", instr, exp_i);
        end else begin
            chk("miss_req", mem_req, 1'b1);
            chk("miss_addr", mem_addr, {a[63:3], 3'b000});
            chk("miss_novalid", instr_valid, 1'b0);
            k = 0; done = 1'b0;
            while (!done) begin
                drove = (k == lat);
                if (drove) begin
                    mem_rvalid = 1'b1; mem_rdata = rd; mem_err = err;
                    fence_i = (fmode == 2);
                end
                @(posedge clk); @(negedge clk);
                mem_rvalid = 1'b0; fence_i = 1'b0;
                if (drove) begin
                    done = 1'b1;
                    exp_f = err;
                    exp_i = err ? FAULT_INS : (a[2] ? rd[63:32] : rd[31:0]);
                    if (!err) begin
                        m_valid = 1'b1; m_tag = a[63:3]; m_line = rd;
                    end
                    if (fmode == 2) m_valid = 1'b0;
                end else if (k == TIMEOUT - 1) begin
                    done = 1'b1;
                    exp_f = 1'b1;
                    exp_i = FAULT_INS;
                end else begin
                    k++;
                    chk("req_hold", {mem_req, instr_valid}, 2'b10);
                end
            end
            chk("resp_valid", instr_valid, 1'b1);
            chk("resp_reqdrop", mem_req, 1'b0);
            chk("resp_fault", fetch_fault, exp_f);
            chk("resp_instr", instr, exp_i);
        end
        @(posedge clk); @(negedge clk);
        chk("pulse_end", {instr_valid, mem_req}, 2'b00);
    endtask

    initial begin
        logic [63:0] a;
        rst = 1'b1; pc = 64'h8000_0000; fence_i = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = 64'h0; mem_err = 1'b0;
        m_valid = 1'b0; m_tag = '0; m_line = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_instr", instr, 32'h0);
        chk("rst_flags", {instr_valid, fetch_fault, mem_req}, 3'b000);
        chk("rst_addr", mem_addr, 64'h0);
        rst = 1'b0;

        // Fill, then hit in the same line, then misaligned
        fetch(64'h8000_0000, 3, 1'b0, 64'h00100093_00000513, 0, 1'b0);
        fetch(64'h8000_0004, 0, 1'b0, 64'h0, 0, 1'b0);
        fetch(64'h8000_0002, 0, 1'b0, 64'h0, 0, 1'b0);
        // Timeout twice on the same line (no fill)
        fetch(64'h8000_0008, 99, 1'b0, 64'h0, 0, 1'b0);
        fetch(64'h8000_0008, 99, 1'b0, 64'h0, 0, 1'b0);
        // Bus error leaves buffer alone
        fetch(64'h8000_0010, 1, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 0, 1'b0);
        fetch(64'h8000_0000, 0, 1'b0, 64'h0, 0, 1'b0);
        // Fence during a hit: still a hit, then the buffer is gone
        fetch(64'h8000_0000, 0, 1'b0, 64'h0, 1, 1'b0);
        fetch(64'h8000_0004, 2, 1'b0, 64'h1111_2222_3333_4444, 0, 1'b0);
        // Data on the timeout cycle is taken; fence alongside fill invalidates
        fetch(64'h8000_0018, TIMEOUT - 1, 1'b0, 64'h5555_6666_7777_8888, 0, 1'b0);
        fetch(64'h8000_001C, 0, 1'b0, 64'h0, 0, 1'b0);
        fetch(64'h8000_0028, 0, 1'b0, 64'h9999_AAAA_BBBB_CCCC, 2, 1'b0);
        fetch(64'h8000_0028, 1, 1'b0, 64'h0123_4567_89AB_CDEF, 0, 1'b0);

        // Reset during MEM aborts the request
        pc = 64'h8000_0020;
        @(posedge clk); @(negedge clk);
        chk("abort_req_up", mem_req, 1'b1);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("abort_req_drop", {mem_req, instr_valid}, 2'b00);
        m_valid = 1'b0;
        rst = 1'b0;
        // Stray rvalid while idle is ignored; the aborted line is still a miss
        fetch(64'h8000_0023, 0, 1'b0, 64'hFFFF_0000_FFFF_0000, 0, 1'b1);
        fetch(64'h8000_0020, 1, 1'b0, 64'hABCD_0001_ABCD_0002, 0, 1'b0);

        // Randomized traffic over a few lines
        for (int i = 0; i < 150; i++) begin
            a = 64'h8000_0000 + 64'($urandom_range(0, 3) << 3) + 64'($urandom_range(0, 1) << 2);
            if ($urandom_range(0, 7) == 0) a = a + 64'($urandom_range(1, 3));
            fetch(a, $urandom_range(0, 9), ($urandom_range(0, 5) == 0), {$urandom, $urandom},
                  ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
